// File: rtl/mips_pkg.sv
// Shared datapath constants and the writeback entry type used by the register-file write port.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO: head visible combinationally, push ignored when full, pop ignored when empty.
// No pass-through: an entry pushed into an empty FIFO is presented at the head from the next cycle.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port: ALU results win unless the long-latency FIFO has starved STARVE_MAX cycles.
// Registered outputs (1-cycle latency); also tracks registers awaiting long-latency results.
module wb_arbiter #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int ADDR_W     = mips_pkg::ADDR_W,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [ADDR_W-1:0]    i_alu_rd,
    input  logic [DATA_W-1:0]    i_alu_data,
    input  logic                 i_mem_valid,
    output logic                 o_mem_ready,
    input  logic [ADDR_W-1:0]    i_mem_rd,
    input  logic [DATA_W-1:0]    i_mem_data,
    input  logic                 i_issue_valid,
    input  logic [ADDR_W-1:0]    i_issue_rd,
    output logic                 o_rf_we,
    output logic [ADDR_W-1:0]    o_rf_waddr,
    output logic [DATA_W-1:0]    o_rf_wdata,
    output logic [2**ADDR_W-1:0] o_pend_mask
);
    import mips_pkg::*;

    localparam int EW   = ADDR_W + DATA_W;
    localparam int NREG = 2 ** ADDR_W;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int CW   = $clog2(DEPTH) + 1;

    logic [EW-1:0]     w_head;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_force;
    logic              w_alu_win;
    logic [ADDR_W-1:0] w_win_rd;
    logic [DATA_W-1:0] w_win_data;
    logic              w_write;
    logic [NREG-1:0]   w_pend_nxt;

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [SW-1:0]     r_starve;
    logic [NREG-1:0]   r_pend;

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat ({i_mem_rd, i_mem_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign w_head_rd   = w_head[EW-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // Ready depends on registered state only, so no combinational path from valid to ready.
    assign w_force     = (r_starve == SW'(STARVE_MAX)) && !w_empty;
    assign o_alu_ready = !w_force;
    assign o_mem_ready = !w_full;
    assign w_push      = i_mem_valid && o_mem_ready;
    assign w_alu_win   = i_alu_valid && !w_force;
    assign w_pop       = !w_alu_win && !w_empty;
    assign w_win_rd    = w_alu_win ? i_alu_rd : w_head_rd;
    assign w_win_data  = w_alu_win ? i_alu_data : w_head_data;
    assign w_write     = (w_alu_win || w_pop) && (w_win_rd != ADDR_W'(REG_ZERO));

    // Set after clear so a same-cycle reissue of the popped register stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_pop && (w_head_rd != ADDR_W'(REG_ZERO))) w_pend_nxt[w_head_rd] = 1'b0;
        if (i_issue_valid) w_pend_nxt[i_issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_starve   <= '0;
            r_pend     <= '0;
        end else begin
            r_rf_we <= w_write;
            if (w_write) begin
                r_rf_waddr <= w_win_rd;
                r_rf_wdata <= w_win_data;
            end
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (w_alu_win && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end
            r_pend <= w_pend_nxt;
        end
    end

    assign o_rf_we     = r_rf_we;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_pend_mask = r_pend;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes queued at stimulus time, popped by a write monitor.
module tb_wb_arbiter;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;

    wb_entry exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_alu_valid  (alu_valid),
        .o_alu_ready  (alu_ready),
        .i_alu_rd     (alu_rd),
        .i_alu_data   (alu_data),
        .i_mem_valid  (mem_valid),
        .o_mem_ready  (mem_ready),
        .i_mem_rd     (mem_rd),
        .i_mem_data   (mem_data),
        .i_issue_valid(issue_valid),
        .i_issue_rd   (issue_rd),
        .o_rf_we      (rf_we),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_pend_mask  (pend_mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wb_entry e;
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd %0d data %h expected no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(e.rd));
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back(wb_entry'{rd: rd, data: data});
    endtask

    task automatic alu_send(input logic [4:0] rd, input logic [31:0] data, output int waits);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
        waits     = 0;
        while (!alu_ready && waits < 20) begin
            tick;
            waits++;
        end
        tick;
    endtask

    task automatic mem_send(input logic [4:0] rd, input logic [31:0] data, output int waits);
        mem_valid = 1'b1;
        mem_rd    = rd;
        mem_data  = data;
        waits     = 0;
        while (!mem_ready && waits < 20) begin
            tick;
            waits++;
        end
        tick;
    endtask

    task automatic drain;
        int k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            tick;
            k++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        #2;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Single ALU write, then an idle cycle
        expect_wr(5'd8, 32'h0000_1234);
        alu_send(5'd8, 32'h1234, w);
        alu_valid = 1'b0;
        chk("alu_we", 32'(rf_we), 32'd1);
        tick;
        chk("idle_we", 32'(rf_we), 32'd0);

        // Issue rd5, then its long-latency result two cycles after the push
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick;
        issue_valid = 1'b0;
        chk("pend_set5", pend_mask, 32'h20);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        mem_send(5'd5, 32'hDEAD_BEEF, w);
        mem_valid = 1'b0;
        chk("mem_lat_cycle1_we", 32'(rf_we), 32'd0);
        tick;
        chk("mem_lat_cycle2_we", 32'(rf_we), 32'd1);
        chk("pend_clear5", pend_mask, 32'h0);
        drain;

        // Fill FIFO while ALU rd0 traffic holds arbitration
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hAAAA_0000;
        for (int i = 1; i <= 5; i++) expect_wr(5'(i), 32'h100 + 32'(i));
        for (int i = 1; i <= 4; i++) mem_send(5'(i), 32'h100 + 32'(i), w);
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        chk("forced_alu_ready", 32'(alu_ready), 32'd0);
        mem_send(5'd5, 32'h105, w);
        chk("fifth_push_waits", 32'(w), 32'd1);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        drain;

        // Starvation: ALU wins three cycles, then FIFO head rd9 is forced through
        expect_wr(5'd10, 32'hA10);
        expect_wr(5'd11, 32'hA11);
        expect_wr(5'd12, 32'hA12);
        expect_wr(5'd9,  32'h99);
        expect_wr(5'd13, 32'hA13);
        mem_send(5'd9, 32'h99, w);
        mem_valid = 1'b0;
        wsum = 0;
        alu_send(5'd10, 32'hA10, w); wsum += w;
        alu_send(5'd11, 32'hA11, w); wsum += w;
        alu_send(5'd12, 32'hA12, w); wsum += w;
        chk("alu_first3_waits", 32'(wsum), 32'd0);
        alu_send(5'd13, 32'hA13, w);
        chk("alu_held_waits", 32'(w), 32'd1);
        alu_valid = 1'b0;
        drain;

        // rd0 handling and same-cycle set/clear
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick;
        chk("pend_bit0", pend_mask, 32'h0);
        issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        chk("pend_set7", pend_mask, 32'h80);
        mem_send(5'd0, 32'h55, w);
        mem_valid = 1'b0;
        alu_send(5'd0, 32'h66, w);
        alu_valid = 1'b0;
        repeat (3) tick;
        chk("pend_after_rd0", pend_mask, 32'h80);
        expect_wr(5'd7, 32'h77);
        mem_send(5'd7, 32'h77, w);
        mem_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        chk("set_wins_we", 32'(rf_we), 32'd1);
        chk("set_wins_pend", pend_mask, 32'h80);
        expect_wr(5'd7, 32'h78);
        mem_send(5'd7, 32'h78, w);
        mem_valid = 1'b0;
        tick;
        chk("pend_clear7", pend_mask, 32'h0);
        drain;

        // Asynchronous reset with two entries buffered and pend 0x0C
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick;
        issue_rd = 5'd3;
        tick;
        issue_valid = 1'b0;
        chk("pend_0c", pend_mask, 32'h0C);
        alu_valid = 1'b1; alu_rd = 5'd0;
        mem_send(5'd2, 32'h222, w);
        mem_send(5'd3, 32'h333, w);
        mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_pend", pend_mask, 32'h0);
        chk("arst_mem_ready", 32'(mem_ready), 32'd1);
        alu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) tick;
        chk("post_rst_we", 32'(rf_we), 32'd0);
        chk("post_rst_pend", pend_mask, 32'h0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
